gene_net_analyzer: RTL and testbench



---
 rtl/gene_net_pkg.sv | 13 +
 rtl/gene_net_step.sv | 15 +
 rtl/gene_net_analyzer.sv | 69 ++++++
 tb/tb_gene_net_analyzer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gene_net_pkg.sv
// Shared constants and types for the Boolean gene-network trajectory analyzer.
package gene_net_pkg;
    localparam int GENE_W     = 8;
    localparam int NUM_STATES = 256;

    typedef logic [GENE_W-1:0] gene_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;
endpackage

// File: rtl/gene_net_step.sv
// One application of the network update rule F: x'[i] = x[i-1] ^ (x[i] & x[i+1]), indices mod 8.
module gene_net_step
    import gene_net_pkg::*;
(
    input  logic [GENE_W-1:0] x_in,
    output logic [GENE_W-1:0] x_out
);
    gene_state_t left_nb;
    gene_state_t right_nb;

    // Rotations line up each gene with its lower and upper ring neighbours.
    assign left_nb  = {x_in[GENE_W-2:0], x_in[GENE_W-1]};
    assign right_nb = {x_in[0], x_in[GENE_W-1:1]};
    assign x_out    = left_nb ^ (x_in & right_nb);
endmodule

// File: rtl/gene_net_analyzer.sv
// Steps an 8-gene Boolean network from a loaded state until it hits a fixed point or revisits a state.
module gene_net_analyzer
    import gene_net_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] init_val,
    output logic [N-1:0] x,
    output logic         fixed,
    output logic         cycle,
    output logic         done,
    output logic [8:0]   steps
);
    fsm_state_t              state;
    logic [NUM_STATES-1:0]   visited;
    gene_state_t             nxt;

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    gene_net_step u_step (
        .x_in  (x),
        .x_out (nxt)
    );

    assign done = fixed | cycle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x       <= '0;
            visited <= '0;
            fixed   <= 1'b0;
            cycle   <= 1'b0;
            steps   <= '0;
        end else if (load) begin
            // A load wipes the whole bitmap so a previous trajectory cannot alias as a cycle.
            state             <= RUN;
            x                 <= init_val;
            visited           <= '0;
            visited[init_val] <= 1'b1;
            fixed             <= 1'b0;
            cycle             <= 1'b0;
            steps             <= '0;
        end else begin
            case (state)
                RUN: begin
                    steps <= sat_inc(steps);
                    // Fixed-point test first: x itself is always in the visited set.
                    if (nxt == x) begin
                        fixed <= 1'b1;
                        state <= DONE;
                    end else if (visited[nxt]) begin
                        cycle <= 1'b1;
                        state <= DONE;
                    end else begin
                        x            <= nxt;
                        visited[nxt] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gene_net_analyzer.sv
// Directed-vector bench for gene_net_analyzer with hand-derived trajectories and an F sweep.
module tb_gene_net_analyzer;
    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] init_val;
    logic [7:0] x;
    logic       fixed;
    logic       cycle;
    logic       done;
    logic [8:0] steps;

    int n_tests = 0;
    int n_fail  = 0;

    gene_net_analyzer #(.N(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .init_val (init_val),
        .x        (x),
        .fixed    (fixed),
        .cycle    (cycle),
        .done     (done),
        .steps    (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] f_model(input logic [7:0] s);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[i] = s[(i + 7) % 8] ^ (s[i] & s[(i + 1) % 8]);
        return r;
    endfunction

    // Drive a one-cycle load strobe; returns at the negedge after the loading edge.
    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        init_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ex, input logic [31:0] ef,
                             input logic [31:0] ec, input logic [31:0] es);
        check({tag, "_x"},     32'(x),     ex);
        check({tag, "_fixed"}, 32'(fixed), ef);
        check({tag, "_cycle"}, 32'(cycle), ec);
        check({tag, "_done"},  32'(done),  ef | ec);
        check({tag, "_steps"}, 32'(steps), es);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        init_val = 8'h00;
        repeat (2) @(negedge clk);
        check_all("reset", 'h00, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed point from 0x00
        do_load(8'h00);
        check_all("z_load", 'h00, 0, 0, 0);
        @(negedge clk);
        check_all("z_e1", 'h00, 1, 0, 1);
        @(negedge clk);
        check_all("z_hold", 'h00, 1, 0, 1);

        // Transient then fixed from 0xFF
        do_load(8'hFF);
        check_all("ff_load", 'hFF, 0, 0, 0);
        @(negedge clk);
        check_all("ff_e1", 'h00, 0, 0, 1);
        @(negedge clk);
        check_all("ff_e2", 'h00, 1, 0, 2);

        // Pure rotation cycle from 0x01
        do_load(8'h01);
        check_all("c_load", 'h01, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check_all($sformatf("c_e%0d", k), 32'(1) << k, 0, 0, 32'(k));
        end
        @(negedge clk);
        check_all("c_e8", 'h80, 0, 1, 8);
        @(negedge clk);
        check_all("c_hold", 'h80, 0, 1, 8);

        // Short sequence from 0x03
        do_load(8'h03);
        @(negedge clk);
        check_all("s_e1", 'h07, 0, 0, 1);
        @(negedge clk);
        check_all("s_e2", 'h0D, 0, 0, 2);

        // Restart with 0xFF in the middle of a 0x01 run
        do_load(8'h01);
        repeat (3) @(negedge clk);
        check_all("r_mid", 'h08, 0, 0, 3);
        do_load(8'hFF);
        check_all("r_load", 'hFF, 0, 0, 0);
        @(negedge clk);
        check_all("r_e1", 'h00, 0, 0, 1);
        @(negedge clk);
        check_all("r_e2", 'h00, 1, 0, 2);

        // Stale visited bits: 0x04 was visited in the aborted run, must not look like a cycle
        do_load(8'h01);
        repeat (3) @(negedge clk);
        do_load(8'h02);
        @(negedge clk);
        check_all("stale_e1", 'h04, 0, 0, 1);

        // Load held high keeps reloading without evaluating
        load     = 1'b1;
        init_val = 8'h01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_all($sformatf("hold%0d", k), 'h01, 0, 0, 0);
        end
        load = 1'b0;

        // Asynchronous reset mid-run, then stay idle with no load
        do_load(8'h01);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all("arst", 'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all("idle", 'h00, 0, 0, 0);

        // One evaluation edge after any load yields F(init)
        for (int v = 0; v < 256; v++) begin
            do_load(8'(v));
            @(negedge clk);
            check($sformatf("sweep_%02h", v), 32'(x), 32'(f_model(8'(v))));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
